// File: rtl/uc.sv
// uc: control unit for the 16-bit datapath, with a RUN / HALTED / STEP
// debug state machine, a sticky reserved-opcode flag and a retire counter.
// Ports:
//   clk, reset (async, active-low)
//   opcode[5:0] : instruction bits [15:10]
//   z           : registered zero flag
//   halt_req, run_req, step_req : debugger requests, level-sampled
//   s_inc, s_inm, we3, wez, op_alu[2:0], pc_en : datapath controls
//   halted, step_ack, illegal, instr_count[15:0] : status
// Parameter BOOT_HALTED selects the state entered out of reset.
// Optional macro UC_INSTR_CNT_EN builds the saturating retire counter;
// without it instr_count is tied to 0.
module uc #(
  parameter bit BOOT_HALTED = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic        z,
  input  logic        halt_req,
  input  logic        run_req,
  input  logic        step_req,
  output logic        s_inc,
  output logic        s_inm,
  output logic        we3,
  output logic        wez,
  output logic [2:0]  op_alu,
  output logic        pc_en,
  output logic        halted,
  output logic        step_ack,
  output logic        illegal,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HALTED = 2'd1,
    S_STEP   = 2'd2
  } state_t;

  localparam state_t RST_ST = BOOT_HALTED ? S_HALTED : S_RUN;

  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_RSVD = 6'b100111;

  state_t r_state;
  state_t w_next;

  logic       w_exec;
  logic       w_retire;
  logic       w_s_inc;
  logic       w_s_inm;
  logic       w_we3;
  logic       w_wez;
  logic [2:0] w_op_alu;
  logic       w_pc_en;
  logic       r_illegal;

  assign w_exec   = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_retire = w_exec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= RST_ST;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_s_inc  = 1'b1;
    w_s_inm  = 1'b0;
    w_we3    = 1'b0;
    w_wez    = 1'b0;
    w_op_alu = 3'b000;
    w_pc_en  = 1'b0;

    if (w_exec) begin
      w_pc_en = 1'b1;
      unique case (1'b1)
        !opcode[5]: begin
          w_op_alu = opcode[4:2];
          w_we3    = 1'b1;
          w_wez    = 1'b1;
        end
        opcode[5:2] == 4'b1000: begin
          w_we3   = 1'b1;
          w_s_inm = 1'b1;
        end
        opcode[5:2] == 4'b1001: begin
          unique case (opcode[1:0])
            2'b00:   w_s_inc = 1'b0;
            2'b01:   w_s_inc = ~z;
            2'b10:   w_s_inc = z;
            default: w_s_inc = 1'b1;
          endcase
        end
        default: begin
          w_s_inc = 1'b1;
        end
      endcase
    end

    unique case (r_state)
      S_RUN: begin
        if (opcode == OP_HALT || halt_req) w_next = S_HALTED;
      end
      S_HALTED: begin
        if (run_req)       w_next = S_RUN;
        else if (step_req) w_next = S_STEP;
      end
      S_STEP:  w_next = S_HALTED;
      default: w_next = RST_ST;
    endcase
  end

  // Writes and PC loads are suppressed for as long as reset is held.
  assign s_inc    = w_s_inc;
  assign s_inm    = w_s_inm;
  assign op_alu   = w_op_alu;
  assign we3      = w_we3 & reset;
  assign wez      = w_wez & reset;
  assign pc_en    = w_pc_en & reset;
  assign halted   = (r_state == S_HALTED);
  assign step_ack = (r_state == S_STEP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_illegal <= 1'b0;
    else if (w_retire && opcode == OP_RSVD)
      r_illegal <= 1'b1;
  end

  assign illegal = r_illegal;

`ifdef UC_INSTR_CNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_cnt <= '0;
    else if (w_retire && r_cnt != 16'hFFFF)
      r_cnt <= r_cnt + 16'd1;
  end

  assign instr_count = r_cnt;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_uc.sv
// tb_uc: directed self-checking bench for uc.
// One task per scenario; summary line at the end.
module tb_uc;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic        z;
  logic        halt_req;
  logic        run_req;
  logic        step_req;
  logic        s_inc;
  logic        s_inm;
  logic        we3;
  logic        wez;
  logic [2:0]  op_alu;
  logic        pc_en;
  logic        halted;
  logic        step_ack;
  logic        illegal;
  logic [15:0] instr_count;

  int checks;
  int failures;

  uc #(.BOOT_HALTED(1'b0)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .opcode     (opcode),
    .z          (z),
    .halt_req   (halt_req),
    .run_req    (run_req),
    .step_req   (step_req),
    .s_inc      (s_inc),
    .s_inm      (s_inm),
    .we3        (we3),
    .wez        (wez),
    .op_alu     (op_alu),
    .pc_en      (pc_en),
    .halted     (halted),
    .step_ack   (step_ack),
    .illegal    (illegal),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    opcode = 6'b000100;
    z = 1'b0;
    halt_req = 1'b0;
    run_req = 1'b0;
    step_req = 1'b0;
    #3;
    checks++;
    if ({pc_en, we3, wez} !== 3'b000) begin
      failures++;
      $display("FAIL rst_gate got=%b exp=000", {pc_en, we3, wez});
    end
    checks++;
    if ({halted, step_ack, illegal} !== 3'b000) begin
      failures++;
      $display("FAIL rst_status got=%b exp=000",
               {halted, step_ack, illegal});
    end
    checks++;
    if (instr_count !== 16'd0) begin
      failures++;
      $display("FAIL rst_cnt got=%h exp=0000", instr_count);
    end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({op_alu, we3, wez, pc_en, halted, s_inm, s_inc}
        !== 9'b001_1110_01) begin
      failures++;
      $display("FAIL boot_alu got=%b exp=001111001",
               {op_alu, we3, wez, pc_en, halted, s_inm, s_inc});
    end
  endtask

  task automatic test_decode();
    opcode = 6'b011011;
    #1;
    checks++;
    if ({op_alu, we3, wez, s_inm, s_inc} !== 7'b110_1101) begin
      failures++;
      $display("FAIL alu110 got=%b exp=1101101",
               {op_alu, we3, wez, s_inm, s_inc});
    end
    opcode = 6'b100010;
    #1;
    checks++;
    if ({we3, wez, s_inm, s_inc, pc_en} !== 5'b10111) begin
      failures++;
      $display("FAIL ldi got=%b exp=10111",
               {we3, wez, s_inm, s_inc, pc_en});
    end
    opcode = 6'b101000;
    #1;
    checks++;
    if ({we3, wez, s_inm, s_inc, pc_en} !== 5'b00011) begin
      failures++;
      $display("FAIL nop got=%b exp=00011",
               {we3, wez, s_inm, s_inc, pc_en});
    end
    tick();
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL nop_ill got=%b exp=0", illegal);
    end
  endtask

  task automatic test_jumps();
    logic [5:0] t_op [6];
    logic       t_z  [6];
    logic       t_si [6];
    t_op = '{6'b100100, 6'b100100, 6'b100101,
             6'b100101, 6'b100110, 6'b100110};
    t_z  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    t_si = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      opcode = t_op[i];
      z = t_z[i];
      #1;
      checks++;
      if ({s_inc, we3, wez, pc_en} !== {t_si[i], 3'b001}) begin
        failures++;
        $display("FAIL jump%0d got=%b exp=%b", i,
                 {s_inc, we3, wez, pc_en}, {t_si[i], 3'b001});
      end
    end
    z = 1'b0;
  endtask

  task automatic test_halt_run();
    opcode = 6'b111111;
    #1;
    checks++;
    if ({pc_en, halted, we3, s_inc} !== 4'b1001) begin
      failures++;
      $display("FAIL halt_op got=%b exp=1001",
               {pc_en, halted, we3, s_inc});
    end
    tick();
    opcode = 6'b000100;
    #1;
    checks++;
    if ({halted, pc_en, we3, wez, op_alu} !== 7'b1000_000) begin
      failures++;
      $display("FAIL halted got=%b exp=1000000",
               {halted, pc_en, we3, wez, op_alu});
    end
    tick();
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_hold got=%b exp=1", halted);
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    checks++;
    if ({halted, pc_en, we3} !== 3'b011) begin
      failures++;
      $display("FAIL resume got=%b exp=011", {halted, pc_en, we3});
    end
    halt_req = 1'b1;
    #1;
    checks++;
    if ({halted, pc_en} !== 2'b01) begin
      failures++;
      $display("FAIL hreq_cur got=%b exp=01", {halted, pc_en});
    end
    tick();
    checks++;
    if (halted !== 1'b1) begin
      failures++;
      $display("FAIL hreq_next got=%b exp=1", halted);
    end
    tick();
    halt_req = 1'b0;
  endtask

  task automatic test_step();
    step_req = 1'b1;
    tick();
    checks++;
    if ({step_ack, halted, pc_en, we3} !== 4'b1011) begin
      failures++;
      $display("FAIL step1 got=%b exp=1011",
               {step_ack, halted, pc_en, we3});
    end
    tick();
    checks++;
    if ({step_ack, halted, pc_en} !== 3'b010) begin
      failures++;
      $display("FAIL step_h got=%b exp=010", {step_ack, halted, pc_en});
    end
    tick();
    checks++;
    if ({step_ack, halted} !== 2'b10) begin
      failures++;
      $display("FAIL step2 got=%b exp=10", {step_ack, halted});
    end
    step_req = 1'b0;
    tick();
    checks++;
    if ({step_ack, halted} !== 2'b01) begin
      failures++;
      $display("FAIL step_end got=%b exp=01", {step_ack, halted});
    end
    run_req = 1'b1;
    step_req = 1'b1;
    tick();
    run_req = 1'b0;
    step_req = 1'b0;
    checks++;
    if ({step_ack, halted, pc_en} !== 3'b001) begin
      failures++;
      $display("FAIL run_wins got=%b exp=001",
               {step_ack, halted, pc_en});
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    checks++;
    if (step_ack !== 1'b1) begin
      failures++;
      $display("FAIL step3 got=%b exp=1", step_ack);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({step_ack, halted, pc_en} !== 3'b000) begin
      failures++;
      $display("FAIL step_abort got=%b exp=000",
               {step_ack, halted, pc_en});
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_illegal();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    opcode = 6'b100111;
    tick();
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL ill_halted got=%b exp=0", illegal);
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    #1;
    checks++;
    if ({illegal, s_inc, we3, wez, pc_en} !== 5'b01001) begin
      failures++;
      $display("FAIL ill_cur got=%b exp=01001",
               {illegal, s_inc, we3, wez, pc_en});
    end
    tick();
    opcode = 6'b000000;
    checks++;
    if (illegal !== 1'b1) begin
      failures++;
      $display("FAIL ill_set got=%b exp=1", illegal);
    end
    tick();
    tick();
    checks++;
    if (illegal !== 1'b1) begin
      failures++;
      $display("FAIL ill_sticky got=%b exp=1", illegal);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (illegal !== 1'b0) begin
      failures++;
      $display("FAIL ill_clr got=%b exp=0", illegal);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_count();
    rst_n = 1'b0;
    opcode = 6'b000100;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
`ifdef UC_INSTR_CNT_EN
    checks++;
    if (instr_count !== 16'd5) begin
      failures++;
      $display("FAIL cnt5 got=%0d exp=5", instr_count);
    end
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    repeat (10) tick();
    checks++;
    if (instr_count !== 16'd6) begin
      failures++;
      $display("FAIL cnt_halt got=%0d exp=6", instr_count);
    end
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    repeat (70000) tick();
    checks++;
    if (instr_count !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_sat got=%h exp=ffff", instr_count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (instr_count !== 16'd0) begin
      failures++;
      $display("FAIL cnt_rst got=%h exp=0000", instr_count);
    end
    tick();
    rst_n = 1'b1;
`else
    checks++;
    if (instr_count !== 16'd0) begin
      failures++;
      $display("FAIL cnt_off got=%h exp=0000", instr_count);
    end
`endif
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_decode();
    test_jumps();
    test_halt_run();
    test_step();
    test_illegal();
    test_count();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uc.md
UC -- requirements
Module: uc

Interface
REQ-001 Parameter BOOT_HALTED, default 0: state entered when reset is released; 0 = RUN, 1 = HALTED.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction bits [15:10] from the datapath.
REQ-005 z  input  1  registered zero flag from the datapath.
REQ-006 halt_req, run_req, step_req  input  1 each  debugger requests, level-sampled each cycle.
REQ-007 s_inc  output  1  1 = PC+1, 0 = PC loads instruction bits [9:0].
REQ-008 s_inm  output  1  1 = register write data is the immediate.
REQ-009 we3, wez  output  1 each  register-file write enable and zero-flag write enable.
REQ-010 op_alu  output  3  ALU operation select.
REQ-011 pc_en  output  1  PC load enable; PC holds when 0.
REQ-012 halted  output  1  high while the state is HALTED.
REQ-013 step_ack  output  1  high during the single STEP cycle.
REQ-014 illegal  output  1  sticky flag for a reserved opcode.
REQ-015 instr_count  output  16  retired-instruction count.

Function
REQ-016 ALU op, opcode[5]=0: op_alu=opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1; opcode[1:0] ignored because those bits are register-field bits.
REQ-017 Load immediate, opcode[5:2]=1000: we3=1, s_inm=1, wez=0, s_inc=1.
REQ-018 Jumps, opcode[5:2]=1001: 00=J (s_inc=0); 01=JZ (s_inc=~z); 10=JNZ (s_inc=z); 11=reserved (NOP, sets illegal); no writes.
REQ-019 HALT is 6'b111111: no writes, s_inc=1, pc_en=1, next state HALTED.
REQ-020 Every other encoding is a NOP: no writes, s_inc=1, pc_en=1; illegal is not set.
REQ-021 States are RUN, HALTED and STEP; the decode of REQ-016..019 is applied only in RUN and STEP.
REQ-022 HALTED: we3=0, wez=0, pc_en=0, s_inc=1, s_inm=0, op_alu=0.
REQ-023 RUN: a HALT opcode or halt_req moves to HALTED; the current-cycle instruction still completes.
REQ-024 HALTED: run_req moves to RUN; otherwise step_req moves to STEP; run_req wins if both are set; halt_req is ignored.
REQ-025 STEP executes exactly one instruction, then always moves to HALTED; step_ack=1 only in the STEP cycle.
REQ-026 An instruction retires in every RUN or STEP cycle, including NOP and HALT.
REQ-027 illegal is set in the cycle after a retired reserved jump and stays set until reset.
REQ-028 All outputs except halted, step_ack, illegal and instr_count are combinational from state, opcode and z.

Reset
REQ-029 Asserting reset low asynchronously forces: state per BOOT_HALTED, illegal=0, instr_count=0.
REQ-030 While reset is low, pc_en=0, we3=0 and wez=0 regardless of state.
REQ-031 Reset asserted during STEP aborts the step; step_ack drops immediately.

Configuration
REQ-032 Macro UC_INSTR_CNT_EN defined: instr_count increments by 1 per retired instruction and saturates at 16'hFFFF.
REQ-033 Macro UC_INSTR_CNT_EN undefined: the counter is not built, instr_count is tied to 0, and the port remains present.

Verification
REQ-034 Reset released with BOOT_HALTED=0, opcode=6'b000100 -> RUN, op_alu=3'b001, we3=1, wez=1, pc_en=1, halted=0.
REQ-035 JZ (6'b100101) with z=1 -> s_inc=0; same opcode with z=0 -> s_inc=1; JNZ gives the inverse; we3=wez=0 in all cases.
REQ-036 RUN, HALT opcode -> pc_en=1 that cycle; next cycle halted=1, pc_en=0; run_req=1 -> RUN in the following cycle.
REQ-037 HALTED, step_req held high for 3 cycles -> exactly one STEP cycle with step_ack=1, then HALTED, then STEP again; run_req and step_req together -> RUN.
REQ-038 Opcode 6'b100111 retired -> illegal=1 from the next cycle, s_inc=1; illegal holds until reset goes low.
REQ-039 With UC_INSTR_CNT_EN defined: 70000 RUN cycles -> instr_count=16'hFFFF; 10 HALTED cycles -> unchanged; reset low mid-run -> 0 immediately.
